// File: rtl/nios_system_interval_timer_master.sv
// rtl/nios_system_interval_timer_master.sv - command-driven bus master for an interval timer slave
// Services slave interrupts in hardware: status read, clear write, tick accounting.
module nios_system_interval_timer_master #(
  parameter int READ_LATENCY = 1,
  parameter int AUTO_SERVICE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_address,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        irq,
  output logic        tick_pulse,
  output logic [15:0] tick_count,
  output logic [1:0]  last_status
);

  typedef enum logic [3:0] {
    IDLE, WR, RD_ISSUE, RD_WAIT, RSP, IRQ_RD, IRQ_WAIT, IRQ_CLR, IRQ_GUARD
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        ready_q;
  logic [15:0] tick_q;
  logic        irq_go;
  logic        accept;

  // ready_q is only ever set on entry to IDLE; the irq gate keeps a colliding command unaccepted
  assign irq_go     = (AUTO_SERVICE != 0) && irq && (state == IDLE);
  assign cmd_ready  = ready_q && !irq_go;
  assign accept     = cmd_valid && cmd_ready;
  assign tick_count = tick_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      ready_q     <= 1'b0;
      chipselect  <= 1'b0;
      write_n     <= 1'b1;
      address     <= 3'd0;
      writedata   <= 16'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'd0;
      tick_pulse  <= 1'b0;
      tick_q      <= 16'd0;
      last_status <= 2'b00;
    end else begin
      rsp_valid  <= 1'b0;
      tick_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (irq_go) begin
            state      <= IRQ_RD;
            ready_q    <= 1'b0;
            chipselect <= 1'b1;
            write_n    <= 1'b1;
            address    <= 3'd0;
          end else if (accept) begin
            ready_q    <= 1'b0;
            chipselect <= 1'b1;
            address    <= cmd_address;
            if (cmd_write) begin
              state     <= WR;
              write_n   <= 1'b0;
              writedata <= cmd_wdata;
            end else begin
              state   <= RD_ISSUE;
              write_n <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        WR: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          ready_q    <= 1'b1;
          state      <= IDLE;
        end
        RD_ISSUE: begin
          chipselect <= 1'b0;
          wait_cnt   <= 8'd0;
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rsp_rdata <= readdata;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RSP: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        IRQ_RD: begin
          chipselect <= 1'b0;
          wait_cnt   <= 8'd0;
          state      <= IRQ_WAIT;
        end
        IRQ_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            last_status <= readdata[1:0];
            chipselect  <= 1'b1;
            write_n     <= 1'b0;
            address     <= 3'd0;
            writedata   <= 16'd0;
            tick_pulse  <= 1'b1;
            tick_q      <= tick_q + 16'd1;
            state       <= IRQ_CLR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        IRQ_CLR: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          state      <= IRQ_GUARD;
        end
        IRQ_GUARD: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          ready_q    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_interval_timer_master.sv
// tb/tb_nios_system_interval_timer_master.sv - directed self-checking bench for the timer master
module tb_nios_system_interval_timer_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_write, irq;
  logic [2:0]  cmd_address;
  logic [15:0] cmd_wdata, readdata;
  logic        cmd_ready, rsp_valid, chipselect, write_n, tick_pulse;
  logic [15:0] rsp_rdata, writedata, tick_count;
  logic [2:0]  address;
  logic [1:0]  last_status;

  logic        na_cmd_ready, na_rsp_valid, na_chipselect, na_write_n, na_tick_pulse;
  logic [15:0] na_rsp_rdata, na_writedata, na_tick_count;
  logic [2:0]  na_address;
  logic [1:0]  na_last_status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios_system_interval_timer_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .tick_pulse(tick_pulse),
    .tick_count(tick_count), .last_status(last_status)
  );

  nios_system_interval_timer_master #(.READ_LATENCY(1), .AUTO_SERVICE(0)) dut_na (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(na_cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata), .address(na_address),
    .chipselect(na_chipselect), .write_n(na_write_n), .writedata(na_writedata),
    .readdata(readdata), .irq(irq), .tick_pulse(na_tick_pulse),
    .tick_count(na_tick_count), .last_status(na_last_status)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({chipselect, write_n, address, writedata, rsp_valid, rsp_rdata, tick_pulse, tick_count, last_status, cmd_ready}
        !== {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 2'b00, 1'b0}) begin
      errors++; $display("FAIL reset_values: cs=%b wn=%b a=%0d wd=%h rv=%b rd=%h tp=%b tc=%h ls=%b rdy=%b",
        chipselect, write_n, address, writedata, rsp_valid, rsp_rdata, tick_pulse, tick_count, last_status, cmd_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write();
    int cs_n = 0;
    int rsp_n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd2; cmd_wdata = 16'h5E0F;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({chipselect, write_n, address, writedata, rsp_valid} !== {1'b1, 1'b0, 3'd2, 16'h5E0F, 1'b0}) begin
      errors++; $display("FAIL write_bus: got cs=%b wn=%b a=%0d wd=%h rv=%b expected cs=1 wn=0 a=2 wd=5e0f rv=0",
        chipselect, write_n, address, writedata, rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (chipselect) cs_n++;
      if (rsp_valid) rsp_n++;
    end
    checks++; if (cs_n != 0) begin errors++; $display("FAIL write_single_cycle: extra select cycles %0d expected 0", cs_n); end
    checks++; if (rsp_n != 0) begin errors++; $display("FAIL write_no_rsp: rsp_valid cycles %0d expected 0", rsp_n); end
  endtask

  task automatic test_read();
    readdata = 16'hFFFF;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd3;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({chipselect, write_n, address} !== {1'b1, 1'b1, 3'd3}) begin
      errors++; $display("FAIL read_issue: got cs=%b wn=%b a=%0d expected cs=1 wn=1 a=3", chipselect, write_n, address);
    end
    @(negedge clk);
    readdata = 16'h005F;
    checks++;
    if ({chipselect, rsp_valid, address} !== {1'b0, 1'b0, 3'd3}) begin
      errors++; $display("FAIL read_wait: got cs=%b rv=%b a=%0d expected cs=0 rv=0 a=3", chipselect, rsp_valid, address);
    end
    @(negedge clk);
    readdata = 16'hFFFF;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h005F}) begin
      errors++; $display("FAIL read_rsp: got rv=%b rd=%h expected rv=1 rd=005f", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_one_cycle: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_irq();
    readdata = 16'h0000;
    @(negedge clk);
    irq = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL irq_blocks_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if ({chipselect, write_n, address} !== {1'b1, 1'b1, 3'd0}) begin
      errors++; $display("FAIL irq_status_read: got cs=%b wn=%b a=%0d expected cs=1 wn=1 a=0", chipselect, write_n, address);
    end
    @(negedge clk);
    readdata = 16'h0003;
    @(negedge clk);
    readdata = 16'h0000;
    checks++;
    if ({chipselect, write_n, address, writedata, tick_pulse, tick_count, last_status}
        !== {1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 16'd1, 2'b11}) begin
      errors++; $display("FAIL irq_clear: got cs=%b wn=%b a=%0d wd=%h tp=%b tc=%h ls=%b expected cs=1 wn=0 a=0 wd=0 tp=1 tc=1 ls=11",
        chipselect, write_n, address, writedata, tick_pulse, tick_count, last_status);
    end
    irq = 1'b0;
    @(negedge clk);
    checks++;
    if ({chipselect, write_n, tick_pulse, cmd_ready} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL irq_guard: got cs=%b wn=%b tp=%b rdy=%b expected cs=0 wn=1 tp=0 rdy=0",
        chipselect, write_n, tick_pulse, cmd_ready);
    end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL irq_return_idle: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd5; cmd_wdata = 16'h1234; irq = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL coll_ready_low: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if ({chipselect, write_n, address, cmd_ready} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL coll_irq_first: got cs=%b wn=%b a=%0d rdy=%b expected cs=1 wn=1 a=0 rdy=0",
        chipselect, write_n, address, cmd_ready);
    end
    @(negedge clk);
    readdata = 16'h0001;
    @(negedge clk);
    readdata = 16'h0000;
    irq = 1'b0;
    checks++;
    if ({tick_pulse, tick_count, last_status} !== {1'b1, 16'd2, 2'b01}) begin
      errors++; $display("FAIL coll_service: got tp=%b tc=%h ls=%b expected tp=1 tc=2 ls=01", tick_pulse, tick_count, last_status);
    end
    @(negedge clk);
    checks++;
    if ({chipselect, cmd_ready} !== {1'b0, 1'b0}) begin
      errors++; $display("FAIL coll_guard: got cs=%b rdy=%b expected cs=0 rdy=0", chipselect, cmd_ready);
    end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_after_guard: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 3'd5, 16'h1234}) begin
      errors++; $display("FAIL coll_cmd_write: got cs=%b wn=%b a=%0d wd=%h expected cs=1 wn=0 a=5 wd=1234",
        chipselect, write_n, address, writedata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd4; cmd_wdata = 16'hAAAA;
    @(negedge clk);
    checks++;
    if ({chipselect, address, writedata} !== {1'b1, 3'd4, 16'hAAAA}) begin
      errors++; $display("FAIL b2b_first: got cs=%b a=%0d wd=%h expected cs=1 a=4 wd=aaaa", chipselect, address, writedata);
    end
    cmd_address = 3'd6; cmd_wdata = 16'h5555;
    @(negedge clk);
    checks++;
    if ({chipselect, write_n, cmd_ready} !== {1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL b2b_gap: got cs=%b wn=%b rdy=%b expected cs=0 wn=1 rdy=1", chipselect, write_n, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 3'd6, 16'h5555}) begin
      errors++; $display("FAIL b2b_second: got cs=%b wn=%b a=%0d wd=%h expected cs=1 wn=0 a=6 wd=5555",
        chipselect, write_n, address, writedata);
    end
    @(negedge clk);
    checks++; if (chipselect !== 1'b0) begin errors++; $display("FAIL b2b_end: got cs=%b expected 0", chipselect); end
  endtask

  task automatic service_irq(output bit seen, output logic [15:0] cnt);
    seen = 1'b0;
    cnt  = 16'hxxxx;
    @(negedge clk);
    irq = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tick_pulse === 1'b1) begin
        seen = 1'b1;
        cnt  = tick_count;
      end
    end
    irq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit          seen;
    logic [15:0] cnt;
    force dut.tick_q = 16'hFFFE;
    #1;
    release dut.tick_q;
    service_irq(seen, cnt);
    checks++; if (!seen || cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: seen=%b got %h expected ffff", seen, cnt); end
    service_irq(seen, cnt);
    checks++; if (!seen || cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: seen=%b got %h expected 0000", seen, cnt); end
  endtask

  task automatic test_no_auto();
    @(negedge clk);
    checks++;
    if ({na_tick_count, na_last_status} !== {16'd0, 2'b00}) begin
      errors++; $display("FAIL no_auto_ignored: got tc=%h ls=%b expected tc=0 ls=00", na_tick_count, na_last_status);
    end
  endtask

  task automatic test_reset_mid_read();
    int rsp_n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd1; readdata = 16'hBEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({chipselect, write_n, address, writedata, rsp_valid, rsp_rdata, tick_pulse, tick_count, last_status, cmd_ready}
        !== {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 2'b00, 1'b0}) begin
      errors++; $display("FAIL midread_reset_values: cs=%b wn=%b a=%0d wd=%h rv=%b rd=%h tp=%b tc=%h ls=%b rdy=%b",
        chipselect, write_n, address, writedata, rsp_valid, rsp_rdata, tick_pulse, tick_count, last_status, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midread_ready: got %b expected 1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
    end
    checks++; if (rsp_n != 0) begin errors++; $display("FAIL midread_no_rsp: rsp_valid cycles %0d expected 0", rsp_n); end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 3'd0;
    cmd_wdata = 16'd0; readdata = 16'd0; irq = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_irq();
    test_collision();
    test_back_to_back();
    test_wrap();
    test_no_auto();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
